// File: rtl/eth_axis_tx_pad_pkg.sv
// Shared Ethernet constants, pad FSM state encodings and a byte-enable popcount helper
// for the eth AXI-stream TX stages.
package eth_axis_tx_pad_pkg;

  localparam int ETH_MIN_FRAME_LEN = 60;
  localparam int ETH_HDR_LEN       = 14;
  localparam int ETH_FCS_LEN       = 4;

  localparam logic [0:0] ST_PASS = 1'b0;
  localparam logic [0:0] ST_PAD  = 1'b1;

  // Counts set bits of a tkeep vector zero-extended to the widest supported bus (512 bits).
  function automatic int popcount(input logic [63:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      n += v[i] ? 1 : 0;
    end
    return n;
  endfunction

endpackage

// File: rtl/eth_axis_tx_pad_out_skid.sv
// Registered AXI-stream output with a one-entry temp (skid) register and an early-ready
// signal, so upstream sees a registered ready without losing a beat when the sink stalls.
module axis_out_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_payload,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             s_ready_early,
  output logic [WIDTH-1:0] m_payload,
  output logic             m_valid,
  input  logic             m_ready
);

  logic [WIDTH-1:0] temp_payload;
  logic             temp_valid;
  logic             m_valid_next, temp_valid_next;
  logic             store_in_to_out, store_in_to_temp, store_temp_to_out;
  logic             s_fire;

  assign s_fire = s_valid && s_ready;

  // Ready for next cycle if the sink drains now, or nothing will be left waiting in temp.
  assign s_ready_early = m_ready || (!temp_valid && (!m_valid || !s_fire));

  always_comb begin
    m_valid_next      = m_valid;
    temp_valid_next   = temp_valid;
    store_in_to_out   = 1'b0;
    store_in_to_temp  = 1'b0;
    store_temp_to_out = 1'b0;
    if (s_ready) begin
      if (m_ready || !m_valid) begin
        m_valid_next    = s_fire;
        store_in_to_out = 1'b1;
      end else begin
        temp_valid_next  = s_fire;
        store_in_to_temp = 1'b1;
      end
    end else if (m_ready) begin
      m_valid_next      = temp_valid;
      temp_valid_next   = 1'b0;
      store_temp_to_out = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid      <= 1'b0;
      temp_valid   <= 1'b0;
      s_ready      <= 1'b0;
      m_payload    <= '0;
      temp_payload <= '0;
    end else begin
      m_valid    <= m_valid_next;
      temp_valid <= temp_valid_next;
      s_ready    <= s_ready_early;
      if (store_in_to_out) begin
        m_payload <= s_payload;
      end else if (store_temp_to_out) begin
        m_payload <= temp_payload;
      end
      if (store_in_to_temp) begin
        temp_payload <= s_payload;
      end
    end
  end

endmodule

// File: rtl/eth_axis_tx_pad.sv
// Pads outgoing Ethernet frames with zero bytes up to MIN_FRAME_LENGTH (FCS excluded);
// longer frames pass byte-exact. Output goes through a registered skid stage.
module eth_axis_tx_pad
  import eth_axis_tx_pad_pkg::*;
#(
  parameter int DATA_WIDTH       = 8,
  parameter bit KEEP_ENABLE      = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
  parameter int MIN_FRAME_LENGTH = ETH_MIN_FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy
);

  localparam int CW = $clog2(MIN_FRAME_LENGTH + 1);
  localparam int PW = DATA_WIDTH + KEEP_WIDTH + 2;

  logic [0:0]            state, state_next, state_after;
  logic [CW-1:0]         count, count_next;
  logic                  user_latch, user_latch_next;
  logic                  busy_reg;
  logic [KEEP_WIDTH-1:0] keep_in;
  logic [DATA_WIDTH-1:0] xf_data;
  logic [KEEP_WIDTH-1:0] xf_keep;
  logic                  xf_last, xf_user;
  logic                  xf_valid, xf_ready, xf_ready_early, xf_fire, s_fire;
  logic [PW-1:0]         skid_out;
  logic [KEEP_WIDTH-1:0] skid_keep;
  int                    pc, rem, lim;

  assign keep_in     = KEEP_ENABLE ? s_axis_tkeep : '1;
  assign s_fire      = s_axis_tvalid && s_axis_tready;
  assign xf_valid    = (state == ST_PASS) ? s_fire : 1'b1;
  assign xf_fire     = xf_valid && xf_ready;
  assign state_after = xf_fire ? state_next : state;

  // rem is what is still owed after this beat; lanes from pc upward are zero-filled.
  always_comb begin
    pc              = popcount(64'(keep_in));
    rem             = 0;
    lim             = KEEP_WIDTH;
    xf_data         = s_axis_tdata;
    xf_keep         = keep_in;
    xf_last         = s_axis_tlast;
    xf_user         = s_axis_tuser && s_axis_tlast;
    state_next      = state;
    count_next      = count;
    user_latch_next = user_latch;
    if (state == ST_PASS) begin
      rem = MIN_FRAME_LENGTH - (int'(count) + pc);
      if (!s_axis_tlast) begin
        count_next = (rem <= 0) ? CW'(MIN_FRAME_LENGTH) : CW'(int'(count) + pc);
      end else begin
        count_next = '0;
        if (rem > 0) begin
          if (rem <= KEEP_WIDTH - pc) begin
            lim = pc + rem;
          end else begin
            xf_last         = 1'b0;
            xf_user         = 1'b0;
            user_latch_next = s_axis_tuser;
            state_next      = ST_PAD;
            count_next      = CW'(int'(count) + KEEP_WIDTH);
          end
          for (int i = 0; i < KEEP_WIDTH; i++) begin
            if (i >= pc) begin
              xf_data[i*8 +: 8] = '0;
            end
            xf_keep[i] = (i < lim);
          end
        end
      end
    end else begin
      rem     = MIN_FRAME_LENGTH - int'(count);
      xf_data = '0;
      xf_keep = '1;
      xf_last = 1'b0;
      xf_user = 1'b0;
      if (rem <= KEEP_WIDTH) begin
        xf_last    = 1'b1;
        xf_user    = user_latch;
        state_next = ST_PASS;
        count_next = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
          xf_keep[i] = (i < rem);
        end
      end else begin
        count_next = CW'(int'(count) + KEEP_WIDTH);
      end
    end
  end

  // Input ready stays low for the whole pad run; it is a subset of the skid's own ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_PASS;
      count         <= '0;
      user_latch    <= 1'b0;
      busy_reg      <= 1'b0;
      s_axis_tready <= 1'b0;
    end else begin
      s_axis_tready <= xf_ready_early && (state_after == ST_PASS);
      if (xf_fire) begin
        state      <= state_next;
        count      <= count_next;
        user_latch <= user_latch_next;
      end
      if (xf_fire && xf_last) begin
        busy_reg <= 1'b0;
      end else if (s_fire) begin
        busy_reg <= 1'b1;
      end
    end
  end

  axis_out_skid #(
    .WIDTH(PW)
  ) u_out_skid (
    .clk          (clk),
    .rst          (rst),
    .s_payload    ({xf_data, xf_keep, xf_last, xf_user}),
    .s_valid      (xf_valid),
    .s_ready      (xf_ready),
    .s_ready_early(xf_ready_early),
    .m_payload    (skid_out),
    .m_valid      (m_axis_tvalid),
    .m_ready      (m_axis_tready)
  );

  assign {m_axis_tdata, skid_keep, m_axis_tlast, m_axis_tuser} = skid_out;
  assign m_axis_tkeep = KEEP_ENABLE ? skid_keep : '1;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_eth_axis_tx_pad.sv
// Scoreboard bench for eth_axis_tx_pad at 64-bit width: random frames are padded by a
// byte-level reference model, and a monitor pops expected beats as the DUT emits them.
module tb_eth_axis_tx_pad;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int MIN = 60;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk, rst;
  logic [DW-1:0] s_axis_tdata, m_axis_tdata;
  logic [KW-1:0] s_axis_tkeep, m_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast, s_axis_tuser;
  logic          m_axis_tvalid, m_axis_tready, m_axis_tlast, m_axis_tuser;
  logic          busy;

  beat_t         expQ[$];
  int            assertCount = 0;
  int            failCount   = 0;
  int            readyMode   = 0;
  logic          prevStall   = 1'b0;
  logic [DW-1:0] prevData;
  logic [KW+1:0] prevCtrl;

  eth_axis_tx_pad #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .busy(busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // readyMode: 0 = sink stalled, 1 = always ready, 2 = random 50% ready
  initial begin
    int mode;
    m_axis_tready = 1'b0;
    forever begin
      @(posedge clk);
      mode = readyMode;
      #1;
      m_axis_tready = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
    end
  endtask

  task automatic reportTimeout(input string name);
    assertCount++;
    failCount++;
    $display("[TB] FAIL %s at %0t: got timeout, expected completion", name, $time);
  endtask

  // Reference model: frame bytes padded with zeros to MIN, chopped into KW-byte beats.
  task automatic applyStimulus(input int len, input logic user, input int gapPct);
    logic [7:0] frameBytes[$];
    logic [7:0] outBytes[$];
    beat_t      e;
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    int nOut, nIn, waitCycles;
    for (int i = 0; i < len; i++) frameBytes.push_back(8'($urandom));
    outBytes = frameBytes;
    while (outBytes.size() < MIN) outBytes.push_back(8'h00);
    nOut = (outBytes.size() + KW - 1) / KW;
    for (int b = 0; b < nOut; b++) begin
      e = '0;
      for (int l = 0; l < KW; l++) begin
        if (b * KW + l < outBytes.size()) begin
          e.data[l*8 +: 8] = outBytes[b*KW + l];
          e.keep[l] = 1'b1;
        end
      end
      e.last = (b == nOut - 1);
      e.user = e.last ? user : 1'b0;
      expQ.push_back(e);
    end
    nIn = (len == 0) ? 1 : (len + KW - 1) / KW;
    for (int b = 0; b < nIn; b++) begin
      data = {$urandom, $urandom};
      keep = '0;
      for (int l = 0; l < KW; l++) begin
        if (b * KW + l < len) begin
          data[l*8 +: 8] = frameBytes[b*KW + l];
          keep[l] = 1'b1;
        end
      end
      while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk);
        #1;
      end
      s_axis_tdata  = data;
      s_axis_tkeep  = keep;
      s_axis_tvalid = 1'b1;
      s_axis_tlast  = (b == nIn - 1);
      s_axis_tuser  = s_axis_tlast ? user : 1'($urandom_range(0, 1));
      waitCycles = 0;
      forever begin
        @(negedge clk);
        if (s_axis_tready) break;
        waitCycles++;
        if (waitCycles > 2000) begin
          reportTimeout("s_ready_wait");
          break;
        end
      end
      @(posedge clk);
      #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
  endtask

  task automatic waitDrain();
    int cycles;
    cycles = 0;
    while (expQ.size() != 0 && cycles < 5000) begin
      @(posedge clk);
      cycles++;
    end
    @(posedge clk);
    #1;
    checkOutput("drain_queue_empty", 64'(expQ.size()), 64'd0);
  endtask

  // Monitor: compares each accepted output beat and checks stability across stalls.
  always @(negedge clk) begin
    beat_t e;
    logic [DW-1:0] mask;
    if (rst) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid_hold", 64'(m_axis_tvalid), 64'd1);
        checkOutput("stall_data_hold", m_axis_tdata, prevData);
        checkOutput("stall_ctrl_hold", 64'({m_axis_tkeep, m_axis_tlast, m_axis_tuser}), 64'(prevCtrl));
      end
      if (m_axis_tvalid && m_axis_tready) begin
        if (expQ.size() == 0) begin
          assertCount++;
          failCount++;
          $display("[TB] FAIL unexpected_beat at %0t: got data 0x%0h, expected no beat", $time, m_axis_tdata);
        end else begin
          e = expQ.pop_front();
          mask = '0;
          for (int l = 0; l < KW; l++) if (e.keep[l]) mask[l*8 +: 8] = 8'hFF;
          checkOutput("beat_data", m_axis_tdata & mask, e.data);
          checkOutput("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
          checkOutput("beat_last", 64'(m_axis_tlast), 64'(e.last));
          checkOutput("beat_user", 64'(m_axis_tuser), 64'(e.user));
        end
      end
      prevStall = m_axis_tvalid && !m_axis_tready;
      prevData  = m_axis_tdata;
      prevCtrl  = {m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    end
  end

  initial begin
    rst           = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    s_axis_tuser  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("reset_m_tlast", 64'(m_axis_tlast), 64'd0);
    checkOutput("reset_m_tuser", 64'(m_axis_tuser), 64'd0);
    checkOutput("reset_m_tdata", m_axis_tdata, 64'd0);
    checkOutput("reset_m_tkeep", 64'(m_axis_tkeep), 64'd0);
    checkOutput("reset_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    #1;
    checkOutput("s_tready_before_edge", 64'(s_axis_tready), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("s_tready_after_edge", 64'(s_axis_tready), 64'd1);
    readyMode = 1;

    $display("[TB] directed frames");
    applyStimulus(14, 1'b0, 0);
    applyStimulus(60, 1'b0, 0);
    applyStimulus(1514, 1'b0, 0);
    applyStimulus(57, 1'b0, 0);
    applyStimulus(0, 1'b0, 0);
    applyStimulus(1, 1'b1, 0);
    applyStimulus(59, 1'b1, 0);
    applyStimulus(61, 1'b1, 0);
    waitDrain();
    checkOutput("idle_busy", 64'(busy), 64'd0);
    checkOutput("idle_m_tvalid", 64'(m_axis_tvalid), 64'd0);

    $display("[TB] back-to-back and random frames, random sink ready");
    readyMode = 2;
    repeat (4) applyStimulus(14, 1'($urandom_range(0, 1)), 0);
    for (int f = 0; f < 40; f++) begin
      applyStimulus(int'($urandom_range(0, 130)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 1) == 1) ? 25 : 0);
    end
    waitDrain();
    checkOutput("random_idle_busy", 64'(busy), 64'd0);

    $display("[TB] reset during pad");
    readyMode = 0;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus(14, 1'b1, 0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("pad_stall_busy", 64'(busy), 64'd1);
    checkOutput("pad_stall_s_tready", 64'(s_axis_tready), 64'd0);
    checkOutput("pad_stall_m_tvalid", 64'(m_axis_tvalid), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("abort_m_tvalid", 64'(m_axis_tvalid), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    expQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    readyMode = 1;
    @(posedge clk);
    #1;
    checkOutput("abort_s_tready", 64'(s_axis_tready), 64'd1);
    applyStimulus(60, 1'b1, 0);
    applyStimulus(14, 1'b0, 0);
    waitDrain();
    checkOutput("final_busy", 64'(busy), 64'd0);

    $display("[TB] End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
